// File: rtl/adc_seq_ctrl.sv
// ADC reset / calibrate / run sequencer with handshake timeouts and an error state.
// Optional build macro ADC_PERIODIC_RECAL_EN: recalibrate automatically after RECAL_PERIOD frames.
module adc_seq_ctrl #(
  parameter int unsigned RST_CYCLES    = 75,
  parameter int unsigned TIMEOUT       = 4096,
  parameter int unsigned SETTLE_CYCLES = 100,
  parameter int unsigned RECAL_PERIOD  = 1024,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 clk_28G,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 recal_req,
  input  logic                 err_clr,
  input  logic                 adc_ready,
  input  logic                 adc_calib_done,
  input  logic                 en_sram,
  output logic                 adc_rst_n,
  output logic                 calib_start,
  output logic                 adc_run,
  output logic [2:0]           state,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [CNT_WIDTH-1:0] frame_cnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RESET    = 3'd1,
    WAIT_RDY = 3'd2,
    CAL_REQ  = 3'd3,
    CAL_WAIT = 3'd4,
    SETTLE   = 3'd5,
    RUN      = 3'd6,
    ERROR    = 3'd7
  } state_t;

  state_t                 cur, nxt;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [1:0]             err_src, err_src_nxt;
  logic                   tmo_hit, rst_last, settle_last, recal_auto;

  // One shared counter times RESET, SETTLE and every handshake; it restarts on each state entry.
  assign tmo_hit     = (TIMEOUT != 0) && (32'(cnt) >= TIMEOUT - 1);
  assign rst_last    = (32'(cnt) + 1 >= RST_CYCLES);
  assign settle_last = (32'(cnt) + 1 >= SETTLE_CYCLES);

`ifdef ADC_PERIODIC_RECAL_EN
  assign recal_auto = (32'(frame_cnt) >= RECAL_PERIOD);
`else
  // Automatic recalibration is compiled out; RECAL_PERIOD has no effect here.
  assign recal_auto = 1'b0 && (RECAL_PERIOD != 0);
`endif

  assign state = cur;

  always_ff @(posedge clk_28G) begin
    if (rst) begin
      cur     <= IDLE;
      cnt     <= '0;
      err_src <= '0;
    end else begin
      cur     <= nxt;
      err_src <= err_src_nxt;
      if (nxt != cur)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    nxt         = cur;
    err_src_nxt = err_src;
    case (cur)
      IDLE: begin
        if (start) nxt = RESET;
      end
      RESET: begin
        if (rst_last) nxt = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (adc_ready) nxt = CAL_REQ;
        else if (tmo_hit) begin
          nxt         = ERROR;
          err_src_nxt = 2'd1;
        end
      end
      CAL_REQ: begin
        if (!adc_ready) nxt = CAL_WAIT;
        else if (tmo_hit) begin
          nxt         = ERROR;
          err_src_nxt = 2'd2;
        end
      end
      CAL_WAIT: begin
        if (adc_calib_done) nxt = SETTLE;
        else if (tmo_hit) begin
          nxt         = ERROR;
          err_src_nxt = 2'd3;
        end
      end
      SETTLE: begin
        if (settle_last) nxt = RUN;
      end
      RUN: begin
        if (stop) nxt = IDLE;
        else if (recal_req || recal_auto) nxt = CAL_REQ;
      end
      ERROR: begin
        if (err_clr) begin
          nxt         = IDLE;
          err_src_nxt = 2'd0;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Outputs decode the settled state, so they follow each transition by one clock.
  always_ff @(posedge clk_28G) begin
    if (rst) begin
      adc_rst_n   <= 1'b1;
      calib_start <= 1'b0;
      adc_run     <= 1'b1;
      err         <= 1'b0;
      err_code    <= '0;
    end else begin
      adc_rst_n   <= (cur != RESET);
      calib_start <= (cur == CAL_REQ);
      adc_run     <= (cur != RUN);
      err         <= (cur == ERROR);
      err_code    <= (cur == ERROR) ? err_src : 2'd0;
    end
  end

  always_ff @(posedge clk_28G) begin
    if (rst)
      frame_cnt <= '0;
    else if (cur != RUN && nxt == RUN)
      frame_cnt <= '0;
    else if (cur == RUN && en_sram && frame_cnt != '1)
      frame_cnt <= frame_cnt + 1'b1;
  end

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Directed bench for adc_seq_ctrl: full bring-up, RUN-phase vector table, stop/recal priority,
// reset during calibration, and WAIT_RDY timeout on a second instance with TIMEOUT=16.
module tb_adc_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, stop = 1'b0, recal_req = 1'b0, err_clr = 1'b0;
  logic adc_ready = 1'b0, adc_calib_done = 1'b0, en_sram = 1'b0;
  logic adc_rst_n, calib_start, adc_run, err;
  logic [2:0] state;
  logic [1:0] err_code;
  logic [15:0] frame_cnt;

  logic t_start = 1'b0, t_err_clr = 1'b0;
  logic t_adc_rst_n, t_calib_start, t_adc_run, t_err;
  logic [2:0] t_state;
  logic [1:0] t_err_code;
  logic [15:0] t_frame_cnt;

  adc_seq_ctrl #(.RECAL_PERIOD(8)) u_dut (
    .clk_28G(clk), .rst(rst), .start(start), .stop(stop), .recal_req(recal_req),
    .err_clr(err_clr), .adc_ready(adc_ready), .adc_calib_done(adc_calib_done),
    .en_sram(en_sram), .adc_rst_n(adc_rst_n), .calib_start(calib_start),
    .adc_run(adc_run), .state(state), .err(err), .err_code(err_code),
    .frame_cnt(frame_cnt)
  );

  adc_seq_ctrl #(.TIMEOUT(16)) u_tmo (
    .clk_28G(clk), .rst(rst), .start(t_start), .stop(1'b0), .recal_req(1'b0),
    .err_clr(t_err_clr), .adc_ready(1'b0), .adc_calib_done(1'b0),
    .en_sram(1'b0), .adc_rst_n(t_adc_rst_n), .calib_start(t_calib_start),
    .adc_run(t_adc_run), .state(t_state), .err(t_err), .err_code(t_err_code),
    .frame_cnt(t_frame_cnt)
  );

  int nvec  = 0;
  int nfail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic en;
    logic rc;
    int   st;
    int   fc;
    int   run;
    int   cal;
  } vec_t;

  vec_t tbl[14];
  int   ntbl;

  task automatic set_vec(input int i, input logic en, input logic rc,
                         input int st, input int fc, input int run, input int cal);
    tbl[i].en = en; tbl[i].rc = rc; tbl[i].st = st;
    tbl[i].fc = fc; tbl[i].run = run; tbl[i].cal = cal;
  endtask

  initial begin
    int n, low;
    logic cal_seen;

    // RUN-phase table: strobes, the RECAL_PERIOD=8 boundary, then a host recal request.
    set_vec(0, 1, 0, 6, 1, 0, 0);
    set_vec(1, 0, 0, 6, 1, 0, 0);
    set_vec(2, 1, 0, 6, 2, 0, 0);
    set_vec(3, 1, 0, 6, 3, 0, 0);
    set_vec(4, 1, 0, 6, 4, 0, 0);
    set_vec(5, 1, 0, 6, 5, 0, 0);
    set_vec(6, 1, 0, 6, 6, 0, 0);
    set_vec(7, 1, 0, 6, 7, 0, 0);
    set_vec(8, 1, 0, 6, 8, 0, 0);
`ifdef ADC_PERIODIC_RECAL_EN
    set_vec(9, 0, 0, 3, 8, 0, 0);
    ntbl = 10;
`else
    set_vec(9, 0, 0, 6, 8, 0, 0);
    set_vec(10, 1, 0, 6, 9, 0, 0);
    set_vec(11, 1, 0, 6, 10, 0, 0);
    set_vec(12, 0, 1, 3, 10, 0, 0);
    set_vec(13, 0, 0, 3, 10, 1, 1);
    ntbl = 14;
`endif

    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_adc_rst_n", adc_rst_n, 1);
    chk("rst_calib_start", calib_start, 0);
    chk("rst_adc_run", adc_run, 1);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;

    // Inputs other than start are ignored in IDLE.
    stop = 1'b1; recal_req = 1'b1; err_clr = 1'b1;
    tick();
    chk("idle_ignore", state, 0);
    stop = 1'b0; recal_req = 1'b0; err_clr = 1'b0;

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_reset", state, 1);
    chk("rst_n_lag", adc_rst_n, 1);

    low = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (adc_rst_n == 1'b0) low++;
      else if (low > 0) break;
    end
    chk("rst_n_low_cycles", low, 75);
    chk("wait_rdy", state, 2);

    adc_ready = 1'b1;
    tick();
    chk("cal_req", state, 3);
    tick();
    chk("calib_start_hi", calib_start, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("calib_start_held", calib_start, 1);
    chk("cal_req_held", state, 3);
    adc_ready = 1'b0;
    tick();
    chk("cal_wait", state, 4);
    tick();
    chk("calib_start_lo", calib_start, 0);

    for (int i = 0; i < 64; i++) tick();
    chk("cal_wait_held", state, 4);
    adc_calib_done = 1'b1;
    tick();
    adc_calib_done = 1'b0;
    chk("settle", state, 5);
    n = 0;
    for (int i = 0; i < 300 && state != 3'd6; i++) begin
      tick();
      n++;
    end
    chk("settle_cycles", n, 100);
    adc_ready = 1'b1;
    tick();
    chk("run_adc_run", adc_run, 0);
    chk("run_frame0", frame_cnt, 0);

    for (int i = 0; i < ntbl; i++) begin
      en_sram = tbl[i].en;
      recal_req = tbl[i].rc;
      tick();
      chk($sformatf("v%0d_state", i), state, tbl[i].st);
      chk($sformatf("v%0d_frame", i), frame_cnt, tbl[i].fc);
      chk($sformatf("v%0d_adc_run", i), adc_run, tbl[i].run);
      chk($sformatf("v%0d_calib", i), calib_start, tbl[i].cal);
    end
    en_sram = 1'b0; recal_req = 1'b0;

    // Recalibrate and re-enter RUN: frame count restarts.
    adc_ready = 1'b0;
    tick();
    chk("recal_cal_wait", state, 4);
    adc_calib_done = 1'b1;
    tick();
    adc_calib_done = 1'b0;
    for (int i = 0; i < 300 && state != 3'd6; i++) tick();
    chk("recal_run", state, 6);
    tick();
    chk("reentry_frame0", frame_cnt, 0);
    chk("reentry_adc_run", adc_run, 0);

    en_sram = 1'b1;
    tick();
    en_sram = 1'b0;
    chk("frame_one", frame_cnt, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_run", state, 6);

    stop = 1'b1; recal_req = 1'b1;
    tick();
    stop = 1'b0; recal_req = 1'b0;
    chk("stop_prio", state, 0);
    cal_seen = calib_start;
    tick();
    cal_seen = cal_seen | calib_start;
    chk("stop_adc_run", adc_run, 1);
    tick();
    cal_seen = cal_seen | calib_start;
    chk("stop_no_calib", cal_seen, 0);
    chk("stop_idle", state, 0);

    // Reset asserted mid-calibration.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 300 && state != 3'd2; i++) tick();
    adc_ready = 1'b1;
    tick();
    adc_ready = 1'b0;
    tick();
    tick();
    chk("pre_rst_cal_wait", state, 4);
    rst = 1'b1;
    tick();
    chk("midrst_state", state, 0);
    chk("midrst_adc_rst_n", adc_rst_n, 1);
    chk("midrst_calib", calib_start, 0);
    chk("midrst_adc_run", adc_run, 1);
    chk("midrst_err", err, 0);
    chk("midrst_frame", frame_cnt, 0);
    rst = 1'b0;

    // Timeout instance: adc_ready never rises.
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    for (int i = 0; i < 300 && t_state != 3'd2; i++) tick();
    chk("tmo_wait_rdy", t_state, 2);
    n = 0;
    for (int i = 0; i < 100 && t_state != 3'd7; i++) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, 16);
    tick();
    chk("tmo_err", t_err, 1);
    chk("tmo_err_code", t_err_code, 1);
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    chk("tmo_start_ignored", t_state, 7);
    t_err_clr = 1'b1;
    tick();
    t_err_clr = 1'b0;
    chk("tmo_clr_idle", t_state, 0);
    tick();
    chk("tmo_clr_err", t_err, 0);
    chk("tmo_clr_code", t_err_code, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/adc_seq_ctrl.md
ADC_SEQ_CTRL -- requirements
Module: adc_seq_ctrl

Interface
REQ-001 Parameters SHALL be: RST_CYCLES, default 75, ADC reset pulse length in clocks; TIMEOUT, default 4096, max wait for any ADC handshake; SETTLE_CYCLES, default 100, post-calibration guard; RECAL_PERIOD, default 1024, en_sram strobes between automatic recalibrations; CNT_WIDTH, default 16, width of all internal counters.
REQ-002 clk_28G  in  1  ADC clock; single clock domain.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  host pulse: begin reset/calibrate/run sequence.
REQ-005 stop  in  1  host pulse: leave RUN, return to IDLE.
REQ-006 recal_req  in  1  host pulse: recalibrate while running.
REQ-007 err_clr  in  1  host pulse: leave ERROR.
REQ-008 adc_ready  in  1  from ADC: idle and ready.
REQ-009 adc_calib_done  in  1  from ADC: calibration complete.
REQ-010 en_sram  in  1  from ADC: output data strobe.
REQ-011 adc_rst_n  out  1  to ADC reset, active low.
REQ-012 calib_start  out  1  to ADC calibration request.
REQ-013 adc_run  out  1  to ADC run enable, active low.
REQ-014 state  out  3  current FSM state encoding.
REQ-015 err  out  1  high in ERROR.
REQ-016 err_code  out  2  1=ready timeout, 2=calib ack timeout, 3=calib done timeout.
REQ-017 frame_cnt  out  CNT_WIDTH  en_sram strobes since last RUN entry.

Function
REQ-018 All outputs SHALL be registered; every output changes one clock after the state transition that causes it.
REQ-019 States SHALL be IDLE=0, RESET=1, WAIT_RDY=2, CAL_REQ=3, CAL_WAIT=4, SETTLE=5, RUN=6, ERROR=7.
REQ-020 IDLE: adc_rst_n=1, calib_start=0, adc_run=1; start -> RESET; stop/recal_req/err_clr ignored.
REQ-021 RESET: adc_rst_n=0 for exactly RST_CYCLES clocks, then -> WAIT_RDY.
REQ-022 WAIT_RDY: adc_ready=1 -> CAL_REQ; TIMEOUT clocks without it -> ERROR, err_code=1.
REQ-023 CAL_REQ: calib_start=1 held until adc_ready=0 sampled, then calib_start=0 and -> CAL_WAIT; TIMEOUT -> ERROR, err_code=2.
REQ-024 CAL_WAIT: adc_calib_done=1 -> SETTLE; TIMEOUT -> ERROR, err_code=3.
REQ-025 SETTLE: hold SETTLE_CYCLES clocks -> RUN; frame_cnt cleared on RUN entry.
REQ-026 RUN: adc_run=0; frame_cnt increments on each en_sram=1 cycle, saturating at all-ones.
REQ-027 RUN exits: stop -> IDLE; else recal_req -> CAL_REQ; adc_run returns to 1 the cycle after exit.
REQ-028 Simultaneous stop and recal_req SHALL take stop; start while not in IDLE SHALL be ignored.
REQ-029 ERROR: err=1, adc_run=1, calib_start=0, adc_rst_n=1; err_clr -> IDLE clearing err and err_code; start in ERROR ignored.
REQ-030 Handshake timeout counter SHALL reset on every state entry; TIMEOUT=0 disables timeouts.

Reset
REQ-031 rst=1 at any clock edge SHALL force state=IDLE, adc_rst_n=1, calib_start=0, adc_run=1, err=0, err_code=0, frame_cnt=0, all counters 0, including mid-calibration or mid-run.

Configuration
REQ-032 Macro ADC_PERIODIC_RECAL_EN defined: in RUN, when frame_cnt reaches RECAL_PERIOD and no stop present, FSM SHALL -> CAL_REQ as if recal_req; stop still has priority.
REQ-033 Macro undefined: no automatic recalibration; only recal_req triggers it; RECAL_PERIOD unused.

Verification
REQ-034 rst, then start with ADC model (CALIB_TIME=64) -> adc_rst_n low 75 clocks, calib_start high until adc_ready falls, RUN reached SETTLE_CYCLES=100 clocks after adc_calib_done, adc_run=0.
REQ-035 adc_ready tied 0, TIMEOUT=16 -> ERROR 16 clocks after WAIT_RDY entry, err_code=1; err_clr -> IDLE, err=0.
REQ-036 In RUN, stop and recal_req same cycle -> IDLE, adc_run=1 next cycle, calib_start never asserted.
REQ-037 In RUN, 10 en_sram strobes -> frame_cnt=10; recal_req -> CAL_REQ; re-entry to RUN -> frame_cnt=0.
REQ-038 With ADC_PERIODIC_RECAL_EN, RECAL_PERIOD=8 -> CAL_REQ entered on the cycle after the 8th strobe; without macro -> stays in RUN, frame_cnt=8.
REQ-039 rst asserted during CAL_WAIT -> next clock state=IDLE, all outputs at reset values.
